// File: rtl/ray_cast_nearest_if.sv
// Bundles the job handshake, the result bus and the wall RAM read port of
// ray_cast_nearest.
//   slave  (the ray caster): samples the job inputs and wall_data, and drives
//          wall_addr, busy and the result signals.
//   master (caller plus wall RAM): drives start, the ray inputs, wall_count,
//          result_ready and wall_data.
// Signals:
//   start, ray_x1/y1/x2/y2, ray_len, wall_count : job launch
//   wall_addr -> wall_data (one cycle later)     : wall RAM read,
//                                                   data = {len, y4, x4, y3, x3}
//   busy, result_valid, result_ready             : job status and handshake
//   hit, distance, uv_x, wall_idx                : nearest-hit result
interface ray_cast_nearest_if #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 6,
  parameter int TEX_LOG2  = 6
);
  logic                   start;
  logic [WIDTH-1:0]       ray_x1;
  logic [WIDTH-1:0]       ray_y1;
  logic [WIDTH-1:0]       ray_x2;
  logic [WIDTH-1:0]       ray_y2;
  logic [WIDTH-1:0]       ray_len;
  logic [ADDR_BITS:0]     wall_count;
  logic [ADDR_BITS-1:0]   wall_addr;
  logic [5*WIDTH-1:0]     wall_data;
  logic                   busy;
  logic                   result_valid;
  logic                   result_ready;
  logic                   hit;
  logic [WIDTH-1:0]       distance;
  logic [TEX_LOG2-1:0]    uv_x;
  logic [ADDR_BITS-1:0]   wall_idx;

  modport master (
    output start, ray_x1, ray_y1, ray_x2, ray_y2, ray_len, wall_count,
           wall_data, result_ready,
    input  wall_addr, busy, result_valid, hit, distance, uv_x, wall_idx
  );

  modport slave (
    input  start, ray_x1, ray_y1, ray_x2, ray_y2, ray_len, wall_count,
           wall_data, result_ready,
    output wall_addr, busy, result_valid, hit, distance, uv_x, wall_idx
  );
endinterface

// File: rtl/ray_cast_nearest.sv
// Sequential ray caster: tests one ray against wall_count wall segments read
// from an external wall RAM and reports the nearest valid hit (distance,
// texture column, wall index). A single pair of restoring dividers is shared
// by all walls, one quotient bit per cycle.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset, aborts any job in progress
//   bus   : ray_cast_nearest_if.slave (job inputs, wall RAM port, result)
module ray_cast_nearest #(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8,
  parameter int ADDR_BITS = 6,
  parameter int TEX_LOG2  = 6,
  parameter int TPU_LOG2  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  ray_cast_nearest_if.slave    bus
);

  localparam int CW    = 2*WIDTH + FRAC_BITS;   // intersection numerator/denominator width
  localparam int QW    = 2*WIDTH;               // quotient width = divide cycles
  localparam int HW    = 2*FRAC_BITS;           // dividend bits above the quotient window
  localparam int PW    = WIDTH + QW;            // scale product width
  localparam int CNTW  = $clog2(QW);
  localparam int UV_SH = 2*FRAC_BITS - TPU_LOG2;

  localparam logic [WIDTH-1:0]     DMAX    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [CW-1:0] DEN_MIN = CW'(2**FRAC_BITS);

  typedef enum logic [3:0] {
    IDLE, ADDR, DATA, CALC, CHECK, DIV, SCALE, CMP, DONE
  } state_t;

  state_t state;

  logic signed [WIDTH-1:0] x1, y1, x2, y2, x3, y3, x4, y4;
  logic [WIDTH-1:0]        r_len, w_len;
  logic [ADDR_BITS:0]      count, index, index_nx;
  logic signed [CW-1:0]    den, tnum, unum;
  logic [CW-1:0]           rem_t, rem_u;
  logic [QW-1:0]           q_t, q_u;
  logic                    t_ovf;
  logic [CNTW-1:0]         div_cnt;
  logic [WIDTH-1:0]        d_reg, best_dist;
  logic [TEX_LOG2-1:0]     uv_reg;

  logic                    busy_r, valid_r, hit_r;
  logic [WIDTH-1:0]        dist_r;
  logic [TEX_LOG2-1:0]     uv_r;
  logic [ADDR_BITS-1:0]    idx_r, addr_r;

  assign bus.busy         = busy_r;
  assign bus.result_valid = valid_r;
  assign bus.hit          = hit_r;
  assign bus.distance     = dist_r;
  assign bus.uv_x         = uv_r;
  assign bus.wall_idx     = idx_r;
  assign bus.wall_addr    = addr_r;

  assign index_nx = index + {{ADDR_BITS{1'b0}}, 1'b1};

  // Intersection terms at full precision
  logic signed [CW-1:0] dx12, dy12, dx13, dy13, dx34, dy34;
  logic signed [CW-1:0] den_c, tnum_c, unum_c;

  assign dx12 = CW'(x1) - CW'(x2);
  assign dy12 = CW'(y1) - CW'(y2);
  assign dx13 = CW'(x1) - CW'(x3);
  assign dy13 = CW'(y1) - CW'(y3);
  assign dx34 = CW'(x3) - CW'(x4);
  assign dy34 = CW'(y3) - CW'(y4);

  assign den_c  = dx12 * dy34 - dy12 * dx34;
  assign tnum_c = dx13 * dy34 - dy13 * dx34;
  assign unum_c = -(dx12 * dy13 - dy12 * dx13);

  logic reject;
  assign reject = (den < DEN_MIN) || (tnum < 0) || (unum < 0) || (unum > den);

  // Dividend = num << FRAC_BITS. Its top HW bits preload the remainder; the
  // remaining QW bits are shifted in through the quotient register, which
  // fills with quotient bits from the bottom as they are consumed at the top.
  logic [HW-1:0]  hi_t, hi_u;
  logic [QW-1:0]  lo_t, lo_u;
  logic [CW:0]    den_ext, sh_t, sh_u;
  logic           bit_t, bit_u;

  assign hi_t    = tnum[CW-1:QW-FRAC_BITS];
  assign hi_u    = unum[CW-1:QW-FRAC_BITS];
  assign lo_t    = {tnum[QW-FRAC_BITS-1:0], {FRAC_BITS{1'b0}}};
  assign lo_u    = {unum[QW-FRAC_BITS-1:0], {FRAC_BITS{1'b0}}};
  assign den_ext = {1'b0, den};
  assign sh_t    = {rem_t, q_t[QW-1]};
  assign sh_u    = {rem_u, q_u[QW-1]};
  assign bit_t   = sh_t >= den_ext;
  assign bit_u   = sh_u >= den_ext;

  // If the preloaded remainder already reaches den, t does not fit in QW bits;
  // the distance then saturates.
  logic [PW-1:0]       d_shift;
  logic [WIDTH-1:0]    d_sat;
  logic [TEX_LOG2-1:0] uv_c;

  assign d_shift = (PW'(r_len) * PW'(q_t)) >> FRAC_BITS;
  assign d_sat   = (t_ovf || (d_shift > PW'(DMAX))) ? DMAX : d_shift[WIDTH-1:0];
  assign uv_c    = TEX_LOG2'((PW'(w_len) * PW'(q_u)) >> UV_SH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
      hit_r     <= 1'b0;
      dist_r    <= '0;
      uv_r      <= '0;
      idx_r     <= '0;
      addr_r    <= '0;
      best_dist <= DMAX;
      index     <= '0;
      count     <= '0;
      x1 <= '0; y1 <= '0; x2 <= '0; y2 <= '0;
      x3 <= '0; y3 <= '0; x4 <= '0; y4 <= '0;
      r_len     <= '0;
      w_len     <= '0;
      den       <= '0;
      tnum      <= '0;
      unum      <= '0;
      rem_t     <= '0;
      rem_u     <= '0;
      q_t       <= '0;
      q_u       <= '0;
      t_ovf     <= 1'b0;
      div_cnt   <= '0;
      d_reg     <= '0;
      uv_reg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            x1        <= bus.ray_x1;
            y1        <= bus.ray_y1;
            x2        <= bus.ray_x2;
            y2        <= bus.ray_y2;
            r_len     <= bus.ray_len;
            count     <= bus.wall_count;
            best_dist <= DMAX;
            hit_r     <= 1'b0;
            dist_r    <= '0;
            uv_r      <= '0;
            idx_r     <= '0;
            index     <= '0;
            busy_r    <= 1'b1;
            if (bus.wall_count == '0) begin
              valid_r <= 1'b1;
              state   <= DONE;
            end else begin
              addr_r  <= '0;
              state   <= ADDR;
            end
          end
        end
        ADDR: state <= DATA;
        DATA: begin
          x3    <= bus.wall_data[0*WIDTH +: WIDTH];
          y3    <= bus.wall_data[1*WIDTH +: WIDTH];
          x4    <= bus.wall_data[2*WIDTH +: WIDTH];
          y4    <= bus.wall_data[3*WIDTH +: WIDTH];
          w_len <= bus.wall_data[4*WIDTH +: WIDTH];
          state <= CALC;
        end
        CALC: begin
          if (den_c < 0) begin
            den  <= -den_c;
            tnum <= -tnum_c;
            unum <= -unum_c;
          end else begin
            den  <= den_c;
            tnum <= tnum_c;
            unum <= unum_c;
          end
          state <= CHECK;
        end
        CHECK: begin
          if (reject) begin
            if (index_nx == count) begin
              valid_r <= 1'b1;
              state   <= DONE;
            end else begin
              index   <= index_nx;
              addr_r  <= index_nx[ADDR_BITS-1:0];
              state   <= ADDR;
            end
          end else begin
            rem_t   <= {{(CW-HW){1'b0}}, hi_t};
            rem_u   <= {{(CW-HW){1'b0}}, hi_u};
            q_t     <= lo_t;
            q_u     <= lo_u;
            t_ovf   <= {{(CW+1-HW){1'b0}}, hi_t} >= den_ext;
            div_cnt <= CNTW'(QW-1);
            state   <= DIV;
          end
        end
        DIV: begin
          rem_t <= bit_t ? CW'(sh_t - den_ext) : CW'(sh_t);
          rem_u <= bit_u ? CW'(sh_u - den_ext) : CW'(sh_u);
          q_t   <= {q_t[QW-2:0], bit_t};
          q_u   <= {q_u[QW-2:0], bit_u};
          if (div_cnt == '0) state <= SCALE;
          else               div_cnt <= div_cnt - 1'b1;
        end
        SCALE: begin
          d_reg  <= d_sat;
          uv_reg <= uv_c;
          state  <= CMP;
        end
        CMP: begin
          if (d_reg < best_dist) begin
            best_dist <= d_reg;
            hit_r     <= 1'b1;
            dist_r    <= d_reg;
            uv_r      <= uv_reg;
            idx_r     <= index[ADDR_BITS-1:0];
          end
          if (index_nx == count) begin
            valid_r <= 1'b1;
            state   <= DONE;
          end else begin
            index   <= index_nx;
            addr_r  <= index_nx[ADDR_BITS-1:0];
            state   <= ADDR;
          end
        end
        DONE: begin
          if (bus.result_ready) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ray_cast_nearest.sv
module tb_ray_cast_nearest;
  localparam int W = 16;

  typedef struct {
    logic [W-1:0]         rx1, ry1, rx2, ry2, rlen;
    int unsigned          nw;
    logic [2:0][5*W-1:0]  w;
    logic                 ehit;
    logic [W-1:0]         edist;
    logic [5:0]           euv, eidx, eaddr;
    int                   ecyc;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ray_cast_nearest_if #(.WIDTH(W), .ADDR_BITS(6), .TEX_LOG2(6)) bus ();

  ray_cast_nearest #(
    .WIDTH(W), .FRAC_BITS(8), .ADDR_BITS(6), .TEX_LOG2(6), .TPU_LOG2(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Wall RAM: registered read, data valid one cycle after the address
  logic [5*W-1:0] mem [64];
  always @(posedge clk) bus.wall_data <= mem[bus.wall_addr];

  int passed = 0;
  int total  = 0;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passed++;
  endtask

  function automatic logic [5*W-1:0] mkw(input logic [W-1:0] x3, y3, x4, y4, len);
    return {len, y4, x4, y3, x3};
  endfunction

  function automatic vec_t mkv(input logic [W-1:0] rx1, ry1, rx2, ry2, rlen,
                               input int unsigned nw,
                               input logic [5*W-1:0] w0, w1, w2,
                               input logic ehit, input logic [W-1:0] edist,
                               input logic [5:0] euv, eidx, eaddr, input int ecyc);
    vec_t v;
    v.rx1 = rx1; v.ry1 = ry1; v.rx2 = rx2; v.ry2 = ry2; v.rlen = rlen;
    v.nw = nw; v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
    v.ehit = ehit; v.edist = edist; v.euv = euv; v.eidx = eidx;
    v.eaddr = eaddr; v.ecyc = ecyc;
    return v;
  endfunction

  task automatic launch(input vec_t v);
    for (int unsigned i = 0; i < v.nw; i++) mem[i] = v.w[i];
    bus.ray_x1     = v.rx1;
    bus.ray_y1     = v.ry1;
    bus.ray_x2     = v.rx2;
    bus.ray_y2     = v.ry2;
    bus.ray_len    = v.rlen;
    bus.wall_count = 7'(v.nw);
    bus.start      = 1'b1;
  endtask

  // Cycles counted from the cycle start is presented to the first cycle
  // result_valid is seen.
  task automatic run_job(input vec_t v, output int cyc);
    launch(v);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      bus.start = 1'b0;
    end while (!bus.result_valid && cyc < 400);
  endtask

  task automatic check_job(input string tag, input vec_t v, input int cyc);
    chk({tag, "_valid"},    32'(bus.result_valid), 32'd1);
    chk({tag, "_busy"},     32'(bus.busy),         32'd1);
    chk({tag, "_cycles"},   32'(cyc),              32'(v.ecyc));
    chk({tag, "_hit"},      32'(bus.hit),          32'(v.ehit));
    chk({tag, "_distance"}, 32'(bus.distance),     32'(v.edist));
    chk({tag, "_uv_x"},     32'(bus.uv_x),         32'(v.euv));
    chk({tag, "_wall_idx"}, 32'(bus.wall_idx),     32'(v.eidx));
    chk({tag, "_wall_addr"},32'(bus.wall_addr),    32'(v.eaddr));
  endtask

  task automatic release_result(input string tag);
    bus.result_ready = 1'b1;
    @(posedge clk); #1;
    bus.result_ready = 1'b0;
    chk({tag, "_rel_valid"}, 32'(bus.result_valid), 32'd0);
    chk({tag, "_rel_busy"},  32'(bus.busy),         32'd0);
  endtask

  logic [5*W-1:0] w4, w8, wp, wb, wu, w3, wr;
  int cyc;

  initial begin
    bus.start = 1'b0;
    bus.ray_x1 = '0; bus.ray_y1 = '0; bus.ray_x2 = '0; bus.ray_y2 = '0;
    bus.ray_len = '0; bus.wall_count = '0; bus.result_ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = '0;

    // Q8.8 walls; ray R is (0,0)->(1,0) with length 1.0
    w4 = mkw(16'h0400, 16'hFE00, 16'h0400, 16'h0200, 16'h0400); // x=4, y -2..2
    w8 = mkw(16'h0800, 16'hFE00, 16'h0800, 16'h0200, 16'h0400); // x=8
    wp = mkw(16'h0000, 16'h0100, 16'h0500, 16'h0100, 16'h0400); // parallel
    wb = mkw(16'hFC00, 16'hFE00, 16'hFC00, 16'h0200, 16'h0400); // behind, t<0
    wu = mkw(16'h0400, 16'h0100, 16'h0400, 16'h0300, 16'h0400); // misses, u<0
    w3 = mkw(16'h0300, 16'hFF00, 16'h0300, 16'h0300, 16'h0400); // x=3, u=0.25
    wr = mkw(16'h0400, 16'h0300, 16'h0400, 16'hFF00, 16'h0400); // den<0, u=0.75

    vecs[0] = mkv(0, 0, 16'h0100, 0, 16'h0100, 1, w4, 0, 0,  1, 16'h0400, 32, 0, 0, 39);
    vecs[1] = mkv(0, 0, 16'h0100, 0, 16'h0100, 2, w8, w4, 0, 1, 16'h0400, 32, 1, 1, 77);
    vecs[2] = mkv(0, 0, 16'h0100, 0, 16'h0100, 2, w4, w4, 0, 1, 16'h0400, 32, 0, 1, 77);
    vecs[3] = mkv(0, 0, 16'h0100, 0, 16'h0100, 3, wp, wb, wu, 0, 16'h0000, 0, 0, 2, 13);
    vecs[4] = mkv(0, 0, 16'h0100, 0, 16'h0100, 0, 0, 0, 0,   0, 16'h0000, 0, 0, 2, 1);
    vecs[5] = mkv(0, 0, 16'h0100, 0, 16'h0100, 1, w3, 0, 0,  1, 16'h0300, 16, 0, 0, 39);
    vecs[6] = mkv(0, 0, 16'h0100, 0, 16'h0100, 1, wr, 0, 0,  1, 16'h0400, 48, 0, 0, 39);
    vecs[7] = mkv(0, 0, 16'h0200, 0, 16'h0200, 1, w4, 0, 0,  1, 16'h0400, 32, 0, 0, 39);
    // distance saturates to max positive, which never beats the initial best
    vecs[8] = mkv(0, 0, 16'h0100, 0, 16'h7FFF, 1, w4, 0, 0,  0, 16'h0000, 0, 0, 0, 39);
    vecs[9] = mkv(0, 0, 16'h0100, 0, 16'h0100, 3, wb, w3, w8, 1, 16'h0300, 16, 1, 2, 81);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",      32'(bus.busy),         32'd0);
    chk("rst_valid",     32'(bus.result_valid), 32'd0);
    chk("rst_hit",       32'(bus.hit),          32'd0);
    chk("rst_distance",  32'(bus.distance),     32'd0);
    chk("rst_uv_x",      32'(bus.uv_x),         32'd0);
    chk("rst_wall_idx",  32'(bus.wall_idx),     32'd0);
    chk("rst_wall_addr", 32'(bus.wall_addr),    32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_job(vecs[i], cyc);
      check_job($sformatf("v%0d", i), vecs[i], cyc);
      release_result($sformatf("v%0d", i));
      @(posedge clk); #1;
    end

    // Backpressure: result held, start pulses ignored
    run_job(vecs[0], cyc);
    check_job("bp", vecs[0], cyc);
    for (int i = 0; i < 10; i++) begin
      bus.start      = 1'b1;
      bus.ray_x1     = 16'h1234;
      bus.wall_count = '0;
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", i),    32'(bus.result_valid), 32'd1);
      chk($sformatf("bp%0d_busy", i),     32'(bus.busy),         32'd1);
      chk($sformatf("bp%0d_hit", i),      32'(bus.hit),          32'd1);
      chk($sformatf("bp%0d_distance", i), 32'(bus.distance),     32'h0400);
      chk($sformatf("bp%0d_uv_x", i),     32'(bus.uv_x),         32'd32);
    end
    bus.start = 1'b0;
    release_result("bp");
    chk("bp_keep_hit",      32'(bus.hit),      32'd1);
    chk("bp_keep_distance", 32'(bus.distance), 32'h0400);
    chk("bp_keep_uv_x",     32'(bus.uv_x),     32'd32);

    // Reset in the middle of the divide phase
    @(posedge clk); #1;
    launch(vecs[9]);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("mid_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_busy",      32'(bus.busy),         32'd0);
    chk("mid_valid",     32'(bus.result_valid), 32'd0);
    chk("mid_hit",       32'(bus.hit),          32'd0);
    chk("mid_distance",  32'(bus.distance),     32'd0);
    chk("mid_uv_x",      32'(bus.uv_x),         32'd0);
    chk("mid_wall_idx",  32'(bus.wall_idx),     32'd0);
    chk("mid_wall_addr", 32'(bus.wall_addr),    32'd0);
    @(posedge clk); #1;
    run_job(vecs[0], cyc);
    check_job("post_rst", vecs[0], cyc);
    release_result("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ray_cast_nearest.md
Name: ray_cast_nearest

Overview:
- Sequential, parametrised ray caster: one ray per job, tested against a list of wall segments held in an external wall RAM.
- Returns the nearest valid hit: distance, texture column and wall index.
- Sits between the raycast renderer's column loop and the wall RAM. It replaces the per-wall combinational intersection path with one time-shared iterative divider pair.

Parameters:
- WIDTH, 16, coordinate/result word width (signed fixed point).
- FRAC_BITS, 8, fractional bits of every coordinate, length and distance.
- ADDR_BITS, 6, wall RAM address width (max 2^ADDR_BITS walls).
- TEX_LOG2, 6, log2 of texture width in texels.
- TPU_LOG2, 4, log2 of texels per world unit along a wall.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, pulse that launches a job; ignored while busy=1.
- ray_x1, ray_y1, ray_x2, ray_y2, in, WIDTH each, ray origin P1 and direction point P2; sampled on start.
- ray_len, in, WIDTH, |P2-P1| precomputed by the caller; sampled on start.
- wall_count, in, ADDR_BITS+1, number of walls to scan; sampled on start.
- wall_addr, out, ADDR_BITS, wall RAM read address.
- wall_data, in, 5*WIDTH, {len, y4, x4, y3, x3} with x3 in the LSBs. Valid one cycle after wall_addr.
- busy, out, 1, job in progress.
- result_valid, out, 1, result available.
- result_ready, in, 1, consumer accepts result.
- hit, out, 1, at least one valid intersection.
- distance, out, WIDTH, nearest hit distance (same Q format), saturated.
- uv_x, out, TEX_LOG2, texture column of the nearest hit.
- wall_idx, out, ADDR_BITS, index of the nearest wall.

Behaviour:
- Reset: state IDLE; busy, result_valid, hit, distance, uv_x, wall_idx and wall_addr are all 0. Reset mid-job aborts immediately; busy=0 on the next cycle.
- FSM states: IDLE, ADDR, DATA, CALC, CHECK, DIV, SCALE, CMP, DONE.
- IDLE: when start=1, register the inputs, clear the best-hit registers (best_dist = max positive, hit=0), and set index=0. Go to DONE if wall_count=0, else ADDR. busy=1 from the next cycle.
- ADDR: drive wall_addr=index. DATA: register wall_data.
- CALC: compute in full 2*WIDTH+FRAC_BITS precision:
  - den = (x1-x2)(y3-y4) - (y1-y2)(x3-x4)
  - tnum = (x1-x3)(y3-y4) - (y1-y3)(x3-x4)
  - unum = -((x1-x2)(y1-y3) - (y1-y2)(x1-x3))
  - If den<0, negate all three.
- CHECK: reject the wall if any of these hold:
  - |den| < 2^FRAC_BITS (covers parallel and near-parallel)
  - tnum < 0
  - unum < 0
  - unum > den
  On reject, go to ADDR with index+1, or to DONE if index+1 = wall_count. Otherwise go to DIV.
- DIV: two unsigned restoring dividers run in parallel:
  - t = (tnum << FRAC_BITS) / den
  - u = (unum << FRAC_BITS) / den
  - One quotient bit per cycle, exactly 2*WIDTH cycles, quotient width 2*WIDTH.
- SCALE:
  - d = (ray_len * t) >> FRAC_BITS, saturated to 2^(WIDTH-1)-1.
  - uv = ((len * u) >> (2*FRAC_BITS - TPU_LOG2)) mod 2^TEX_LOG2.
- CMP: if d < best_dist (strict, so ties keep the lower index), update best_dist, uv and idx, and set hit=1. Then advance as in CHECK.
- Per-wall cost: rejected wall is 4 cycles; accepted wall is 2*WIDTH+6 cycles (38 at WIDTH=16).
- DONE: result_valid=1, busy=1. Outputs hold stable until result_ready=1. On that cycle the FSM goes to IDLE; result_valid and busy are 0 next cycle. Outputs keep their values until the next start.
- When hit=0, distance=0, uv_x=0 and wall_idx=0.
- start while busy or in DONE: ignored, no state change.
- wall_addr is held at its last value outside ADDR.

Test Plan:
- Single wall, WIDTH=16, FRAC_BITS=8: ray (0,0)->(1,0), ray_len=0x0100; wall (4,-2)->(4,2), len=0x0400. Required: hit=1, distance=0x0400, uv_x=32, wall_idx=0, result_valid 1+38 cycles after start plus DONE entry.
- Nearest selection: wall0 at x=8, wall1 at x=4 (same span), wall_count=2. Required: hit=1, wall_idx=1, distance=0x0400. Equal-distance duplicate walls: wall_idx is the lower index.
- Rejects: wall (0,1)->(5,1) (parallel), wall (-4,-2)->(-4,2) (t<0), wall (4,1)->(4,3) (u<0). Required: hit=0, distance=0, uv_x=0, and exactly 4 cycles per wall in the ADDR..CHECK loop.
- wall_count=0: result_valid asserted with hit=0 with no wall_addr activity.
- Backpressure: hold result_ready=0 for 10 cycles; outputs stable, start pulses ignored. result_ready=1 clears result_valid and busy on the next cycle.
- Reset asserted mid-DIV: next cycle busy=0, result_valid=0, all outputs 0. A fresh start then yields the correct single-wall result.
